// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline mux select types plus the hazard controller state encoding.
// Select encodings put the plain register-file path at zero so reset yields it.
package forwardmux1;
    typedef enum bit [1:0] {
        idex_rs1reg_out  = 2'd0,
        exmem_alureg_out = 2'd1,
        regfilemux_out   = 2'd2
    } forwardmux1_sel_t;
endpackage

package forwardmux2;
    typedef enum bit [1:0] {
        idex_rs2reg_out  = 2'd0,
        exmem_alureg_out = 2'd1,
        regfilemux_out   = 2'd2
    } forwardmux2_sel_t;
endpackage

package hazardstate;
    typedef enum bit [1:0] {
        run       = 2'd0,
        mem_wait  = 2'd1,
        lu_bubble = 2'd2
    } hazardstate_t;
endpackage

// File: rtl/hazard_ctrl_resp_buf.sv
// Holds one cache port's single-cycle response until the pipe next advances.
// Zero latency on the live response; buffered copy is presented afterwards.
module resp_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            resp,
    input  logic            clr,
    input  logic [XLEN-1:0] rdata,
    output logic            pend,
    output logic [XLEN-1:0] data
);
    logic            done;
    logic [XLEN-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            hold_q <= '0;
        end else begin
            if (clr)
                done <= 1'b0;
            else if (resp && req)
                done <= 1'b1;
            if (resp)
                hold_q <= rdata;
        end
    end

    assign pend = req & ~(resp | done);
    assign data = resp ? rdata : hold_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: EX forwarding selects, load-use bubble, branch flush,
// and a global freeze while either cache port still owes a response.
module hazard_ctrl #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REGW-1:0]                ifid_rs1,
    input  logic [REGW-1:0]                ifid_rs2,
    input  logic [REGW-1:0]                idex_rs1,
    input  logic [REGW-1:0]                idex_rs2,
    input  logic [REGW-1:0]                idex_rd,
    input  logic                           idex_is_load,
    input  logic [REGW-1:0]                exmem_rd,
    input  logic                           exmem_regwrite,
    input  logic                           exmem_is_load,
    input  logic [REGW-1:0]                memwb_rd,
    input  logic                           memwb_regwrite,
    input  logic                           br_taken,
    input  logic                           imem_read,
    input  logic                           dmem_req,
    input  logic                           imem_resp,
    input  logic                           dmem_resp,
    input  logic [XLEN-1:0]                imem_rdata,
    input  logic [XLEN-1:0]                dmem_rdata,
    output forwardmux1::forwardmux1_sel_t  forwardmux1_sel,
    output forwardmux2::forwardmux2_sel_t  forwardmux2_sel,
    output logic                           pipe_stall,
    output logic                           lu_bubble,
    output logic                           flush_ifid,
    output logic                           flush_idex,
    output logic [XLEN-1:0]                if_rdata,
    output logic [XLEN-1:0]                mem_rdata,
    output logic [XLEN-1:0]                stall_cycles
);
    hazardstate::hazardstate_t state_q, state_d;
    logic i_pend, d_pend, mem_pend, load_use, flush;

    resp_buf #(.XLEN(XLEN)) u_ibuf (
        .clk(clk), .rst(rst), .req(imem_read), .resp(imem_resp), .clr(~pipe_stall),
        .rdata(imem_rdata), .pend(i_pend), .data(if_rdata)
    );

    resp_buf #(.XLEN(XLEN)) u_dbuf (
        .clk(clk), .rst(rst), .req(dmem_req), .resp(dmem_resp), .clr(~pipe_stall),
        .rdata(dmem_rdata), .pend(d_pend), .data(mem_rdata)
    );

    assign mem_pend = i_pend | d_pend;
    assign load_use = idex_is_load && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    // Loads in MEM are never forwarded from EX/MEM; the bubble moves them to WB first.
    always_comb begin
        forwardmux1_sel = forwardmux1::idex_rs1reg_out;
        forwardmux2_sel = forwardmux2::idex_rs2reg_out;
        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs1 && !exmem_is_load)
            forwardmux1_sel = forwardmux1::exmem_alureg_out;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs1)
            forwardmux1_sel = forwardmux1::regfilemux_out;
        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == idex_rs2 && !exmem_is_load)
            forwardmux2_sel = forwardmux2::exmem_alureg_out;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_rs2)
            forwardmux2_sel = forwardmux2::regfilemux_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= hazardstate::run;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pipe_stall = 1'b0;
        flush      = 1'b0;
        lu_bubble  = 1'b0;
        case (state_q)
            hazardstate::lu_bubble: begin
                if (mem_pend) begin
                    pipe_stall = 1'b1;
                    state_d    = hazardstate::mem_wait;
                end else begin
                    state_d = hazardstate::run;
                end
            end
            default: begin
                // RUN and the release cycle of MEM_WAIT share the same rules.
                if (mem_pend) begin
                    pipe_stall = 1'b1;
                    state_d    = hazardstate::mem_wait;
                end else if (br_taken) begin
                    flush   = 1'b1;
                    state_d = hazardstate::run;
                end else if (load_use) begin
                    lu_bubble = 1'b1;
                    state_d   = hazardstate::lu_bubble;
                end else begin
                    state_d = hazardstate::run;
                end
            end
        endcase
    end

    assign flush_ifid = flush;
    assign flush_idex = flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (pipe_stall)
            stall_cycles <= stall_cycles + XLEN'(1);
    end

    a_no_load_fwd: assert property (@(posedge clk) disable iff (rst)
        !(!pipe_stall && exmem_is_load && exmem_regwrite && exmem_rd != '0 &&
          (exmem_rd == idex_rs1 || exmem_rd == idex_rs2)));
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations queued with each cycle's stimulus,
// drained and compared on the following falling edge.
module tb_hazard_ctrl;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam int O_FWD1  = 0;
    localparam int O_FWD2  = 1;
    localparam int O_STALL = 2;
    localparam int O_BUB   = 3;
    localparam int O_FIFID = 4;
    localparam int O_FIDEX = 5;
    localparam int O_IFD   = 6;
    localparam int O_MEMD  = 7;
    localparam int O_SCNT  = 8;

    logic clk = 1'b0;
    logic rst;
    logic [REGW-1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic idex_is_load, exmem_regwrite, exmem_is_load, memwb_regwrite, br_taken;
    logic imem_read, dmem_req, imem_resp, dmem_resp;
    logic [XLEN-1:0] imem_rdata, dmem_rdata;
    forwardmux1::forwardmux1_sel_t fwd1;
    forwardmux2::forwardmux2_sel_t fwd2;
    logic pipe_stall, lu_bubble, flush_ifid, flush_idex;
    logic [XLEN-1:0] if_rdata, mem_rdata, stall_cycles;

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_is_load(idex_is_load),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .br_taken(br_taken),
        .imem_read(imem_read), .dmem_req(dmem_req),
        .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
        .forwardmux1_sel(fwd1), .forwardmux2_sel(fwd2),
        .pipe_stall(pipe_stall), .lu_bubble(lu_bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .if_rdata(if_rdata), .mem_rdata(mem_rdata),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, act, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input int which);
        case (which)
            O_FWD1:  return 32'(fwd1);
            O_FWD2:  return 32'(fwd2);
            O_STALL: return 32'(pipe_stall);
            O_BUB:   return 32'(lu_bubble);
            O_FIFID: return 32'(flush_ifid);
            O_FIDEX: return 32'(flush_idex);
            O_IFD:   return if_rdata;
            O_MEMD:  return mem_rdata;
            default: return stall_cycles;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int which, input logic [31:0] val);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.val   = val;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(input string tag, input logic stall, input logic bub, input logic fl);
        expect_out({tag, ".stall"}, O_STALL, 32'(stall));
        expect_out({tag, ".bubble"}, O_BUB, 32'(bub));
        expect_out({tag, ".flush_ifid"}, O_FIFID, 32'(fl));
        expect_out({tag, ".flush_idex"}, O_FIDEX, 32'(fl));
    endtask

    // Compare everything queued for this cycle, then advance to just after the next edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.which), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs1 = '0; ifid_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
        idex_is_load = 1'b0; exmem_rd = '0; exmem_regwrite = 1'b0; exmem_is_load = 1'b0;
        memwb_rd = '0; memwb_regwrite = 1'b0; br_taken = 1'b0;
        imem_read = 1'b0; dmem_req = 1'b0; imem_resp = 1'b0; dmem_resp = 1'b0;
        imem_rdata = '0; dmem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_out("rst.fwd1", O_FWD1, 32'(forwardmux1::idex_rs1reg_out));
        expect_out("rst.fwd2", O_FWD2, 32'(forwardmux2::idex_rs2reg_out));
        expect_ctl("rst", 1'b0, 1'b0, 1'b0);
        expect_out("rst.if_rdata", O_IFD, 32'h0);
        expect_out("rst.mem_rdata", O_MEMD, 32'h0);
        expect_out("rst.scnt", O_SCNT, 32'd0);
        cyc();
        rst = 1'b0;

        // Forwarding priority and zero-register exclusion
        exmem_rd = 5; exmem_regwrite = 1'b1; memwb_rd = 5; memwb_regwrite = 1'b1; idex_rs1 = 5;
        expect_out("fwd.exmem", O_FWD1, 32'(forwardmux1::exmem_alureg_out));
        expect_out("fwd.rs2zero", O_FWD2, 32'(forwardmux2::idex_rs2reg_out));
        cyc();
        exmem_rd = 0;
        expect_out("fwd.memwb", O_FWD1, 32'(forwardmux1::regfilemux_out));
        cyc();
        exmem_rd = 7; idex_rs2 = 7; memwb_rd = 9; idex_rs1 = 9;
        expect_out("fwd.rs2exmem", O_FWD2, 32'(forwardmux2::exmem_alureg_out));
        expect_out("fwd.rs1memwb", O_FWD1, 32'(forwardmux1::regfilemux_out));
        cyc();
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        expect_out("fwd.nowr1", O_FWD1, 32'(forwardmux1::idex_rs1reg_out));
        expect_out("fwd.nowr2", O_FWD2, 32'(forwardmux2::idex_rs2reg_out));
        cyc();

        // Load-use: one bubble, then WB forwarding to the stalled consumer
        clear_inputs();
        idex_is_load = 1'b1; idex_rd = 3; ifid_rs2 = 3;
        expect_ctl("lu.c0", 1'b0, 1'b1, 1'b0);
        cyc();
        exmem_is_load = 1'b1; exmem_rd = 3; exmem_regwrite = 1'b1;
        expect_ctl("lu.c1", 1'b0, 1'b0, 1'b0);
        cyc();
        clear_inputs();
        memwb_rd = 3; memwb_regwrite = 1'b1; idex_rs2 = 3;
        expect_out("lu.fwd2", O_FWD2, 32'(forwardmux2::regfilemux_out));
        expect_ctl("lu.c2", 1'b0, 1'b0, 1'b0);
        cyc();

        // Split responses: I returns at cycle 2, D at cycle 5
        clear_inputs();
        imem_read = 1'b1; dmem_req = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            imem_resp = (c == 2);
            imem_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0;
            dmem_resp = (c == 5);
            dmem_rdata = (c == 5) ? 32'h12345678 : 32'h0;
            expect_out($sformatf("split.stall%0d", c), O_STALL, (c < 5) ? 32'd1 : 32'd0);
            expect_out($sformatf("split.scnt%0d", c), O_SCNT, 32'(c));
            if (c >= 2)
                expect_out($sformatf("split.ifd%0d", c), O_IFD, 32'hDEADBEEF);
            cyc();
        end
        clear_inputs();

        // Branch and load-use together: flush only
        br_taken = 1'b1; idex_is_load = 1'b1; idex_rd = 3; ifid_rs1 = 3;
        expect_ctl("sim", 1'b0, 1'b0, 1'b1);
        cyc();
        clear_inputs();
        expect_ctl("sim.after", 1'b0, 1'b0, 1'b0);
        cyc();

        // Stall beats flush; flush lands on the release cycle
        dmem_req = 1'b1; br_taken = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            dmem_resp = (c == 2);
            expect_ctl($sformatf("sof.c%0d", c), (c < 2), 1'b0, (c == 2));
            expect_out($sformatf("sof.scnt%0d", c), O_SCNT, 32'(5 + c));
            cyc();
        end
        clear_inputs();
        expect_ctl("sof.after", 1'b0, 1'b0, 1'b0);
        cyc();

        // Reset while waiting with I already captured
        imem_read = 1'b1; dmem_req = 1'b1;
        expect_out("rmw.c0", O_STALL, 32'd1);
        cyc();
        imem_resp = 1'b1; imem_rdata = 32'hCAFEF00D;
        expect_out("rmw.c1", O_STALL, 32'd1);
        cyc();
        imem_resp = 1'b0; imem_rdata = '0;
        expect_out("rmw.c2", O_STALL, 32'd1);
        expect_out("rmw.ifd", O_IFD, 32'hCAFEF00D);
        cyc();
        clear_inputs();
        rst = 1'b1;
        expect_ctl("rmw.rst", 1'b0, 1'b0, 1'b0);
        expect_out("rmw.rst.ifd", O_IFD, 32'h0);
        expect_out("rmw.rst.scnt", O_SCNT, 32'd0);
        cyc();
        rst = 1'b0;
        imem_read = 1'b1;
        expect_out("fresh.c0", O_STALL, 32'd1);
        expect_out("fresh.scnt0", O_SCNT, 32'd0);
        cyc();
        expect_out("fresh.c1", O_STALL, 32'd1);
        cyc();
        imem_resp = 1'b1; imem_rdata = 32'hA5A5_0001;
        expect_out("fresh.c2", O_STALL, 32'd0);
        expect_out("fresh.ifd", O_IFD, 32'hA5A5_0001);
        expect_out("fresh.scnt2", O_SCNT, 32'd2);
        cyc();
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control for the 5-stage RV32I core: produces forwardmux1/forwardmux2 selects for the EX stage, load-use bubbles, branch flushes, and global freeze while I/D cache requests are outstanding.
- Buffers single-cycle cache responses that arrive while the other port is still busy, and presents them to IF/MEM when the pipe advances.
- Sits beside the pipeline registers; consumes ID/EX, EX/MEM and MEM/WB register fields.

Parameters:
- XLEN, 32, data width of cache read data and the stall counter.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ifid_rs1, ifid_rs2  in  REGW  sources of the instruction in ID
- idex_rs1, idex_rs2  in  REGW  sources of the instruction in EX
- idex_rd  in  REGW  destination of the instruction in EX
- idex_is_load  in  1  EX instruction is a load
- exmem_rd  in  REGW  destination of the instruction in MEM
- exmem_regwrite  in  1  MEM instruction writes rd
- exmem_is_load  in  1  MEM instruction is a load
- memwb_rd  in  REGW  destination of the instruction in WB
- memwb_regwrite  in  1  WB instruction writes rd
- br_taken  in  1  EX resolved pcmux::alu_out
- imem_read, dmem_req  in  1  cache requests, level, held until the pipe advances
- imem_resp, dmem_resp  in  1  one-cycle response pulses
- imem_rdata, dmem_rdata  in  XLEN  response data, valid with resp
- forwardmux1_sel  out  forwardmux1::forwardmux1_sel_t
- forwardmux2_sel  out  forwardmux2::forwardmux2_sel_t
- pipe_stall  out  1  hold PC and all pipeline registers
- lu_bubble  out  1  hold PC and IF/ID; load NOP into ID/EX
- flush_ifid, flush_idex  out  1  replace the register contents with NOP
- if_rdata, mem_rdata  out  XLEN  live or buffered cache data
- stall_cycles  out  XLEN  count of pipe_stall cycles, wraps

Behaviour:
- Reset (async) values:
  - FSM = RUN, i_done = d_done = 0, buffers = 0, stall_cycles = 0.
  - All outputs 0; selects = idex_rsNreg_out.
- Forwarding (combinational, identical for rs1/rs2):
  - Select exmem_alureg_out if exmem_regwrite, exmem_rd != 0, exmem_rd == idex_rsN, and !exmem_is_load.
  - Otherwise select regfilemux_out if memwb_regwrite, memwb_rd != 0, and memwb_rd == idex_rsN.
  - Otherwise select idex_rsNreg_out.
  - EX/MEM has priority over MEM/WB.
- Response buffering:
  - i_done sets on imem_resp while imem_read is high; d_done likewise for dmem_resp/dmem_req.
  - The buffer captures rdata on the resp cycle.
  - if_rdata = imem_resp ? imem_rdata : i_buf; mem_rdata likewise.
  - Both flags clear on the first cycle pipe_stall == 0.
- FSM states RUN, MEM_WAIT, LU_BUBBLE:
  - i_pend = imem_read & !(imem_resp | i_done); d_pend likewise.
  - RUN:
    - If i_pend | d_pend: pipe_stall = 1, go to MEM_WAIT.
    - Else if br_taken: flush_ifid = flush_idex = 1, stay in RUN.
    - Else if load-use: lu_bubble = 1, go to LU_BUBBLE. Load-use means idex_is_load, idex_rd != 0, and idex_rd matches ifid_rs1 or ifid_rs2.
  - MEM_WAIT:
    - pipe_stall = 1 while i_pend | d_pend.
    - On the cycle both are clear: pipe_stall = 0, then apply the RUN branch/load-use rules that same cycle, and go to RUN or LU_BUBBLE.
  - LU_BUBBLE:
    - Outputs idle unless memory is pending; if pending, pipe_stall = 1 and go to MEM_WAIT.
    - Otherwise go to RUN. Exactly one bubble per load-use.
- Priority: pipe_stall > flush > lu_bubble.
  - br_taken together with load-use yields a flush only, no bubble.
  - Flush and bubble are never asserted while pipe_stall = 1.
- stall_cycles increments every cycle pipe_stall = 1; wraps 2^XLEN−1 → 0.
- Reset mid-MEM_WAIT discards buffered data and flags.
- Assertion: an exmem_is_load match on idex_rsN with pipe_stall = 0 is illegal; the load-use bubble guarantees it never occurs.

Decomposition:
- Add package hazardstate to the shared mux types file: typedef enum bit [1:0] {run, mem_wait, lu_bubble}.
- Reuse the forwardmux1/forwardmux2 enums unchanged.
- One sub-module, resp_buf: a single flag+data capture for one cache port, instantiated twice (I and D).
- Forwarding logic stays inline.

Test Plan:
- Forwarding: exmem_rd = 5, exmem_regwrite = 1, memwb_rd = 5, memwb_regwrite = 1, idex_rs1 = 5 → forwardmux1_sel = exmem_alureg_out. Same with exmem_rd = 0 → regfilemux_out. rs2 = 0 → idex_rs2reg_out.
- Load-use: idex_is_load = 1, idex_rd = 3, ifid_rs2 = 3 → lu_bubble high for exactly 1 cycle. Next cycle exmem_is_load, exmem_rd = 3, idex_rs2 = 3 → forwardmux2_sel = regfilemux_out after advance.
- Split responses: imem_read and dmem_req high, imem_resp at cycle 2 (data 0xDEADBEEF), dmem_resp at cycle 5 → pipe_stall high cycles 0–4, low at 5. if_rdata = 0xDEADBEEF at 5. stall_cycles = 5.
- Simultaneous: br_taken = 1 with a load-use match → flush_ifid = flush_idex = 1, lu_bubble = 0.
- Stall over flush: br_taken = 1 while d_pend → no flush while stalled; flush asserted on the release cycle.
- Reset mid-wait: rst pulsed in MEM_WAIT with i_done = 1 → all outputs 0, stall_cycles = 0. A later imem_read needs a fresh resp.
